spi_aes_frame_ctrl: RTL
=======================

// Module: spi_aes_frame_ctrl
// PURPOSE
//  Frame controller between the 16-bit SPI slave word port and the 128-bit AES core.
//  Decodes a header word per transaction: load key, encrypt block, read status or clear errors.
//  Assembles WORDS received words into the key or plaintext, starts the core and waits for it.
//  Streams the ciphertext back through the slave's transmit register.
// PARAMETERS
//  BLOCK_W      128   AES key/data width
//  WORD_W       16    SPI word width
//  WORDS        8     BLOCK_W/WORD_W, words per block
//  TIMEOUT_CYC  1024  RUN watchdog limit (CTRL_TIMEOUT_EN only)
// PORTS
//  CLK             in   1        system clock, rising edge
//  RST_N           in   1        asynchronous active-low reset
//  SPI_CS          in   1        chip select seen by the slave, active low
//  SPI_DONE        in   1        slave word-complete pulse; rising edge = one new word
//  SPI_RX_WORD     in   WORD_W   received word (slave DATA_OUT), valid on SPI_DONE
//  SPI_TX_WORD     out  WORD_W   word to transmit (slave DATA_IN)
//  SPI_TX_VALID    out  1        one-cycle load strobe for SPI_TX_WORD (slave data_valid)
//  AES_KEY         out  BLOCK_W  key register
//  AES_TEXT        out  BLOCK_W  plaintext register
//  AES_START       out  1        one-cycle start pulse
//  AES_DONE        in   1        core completion pulse
//  AES_RESULT      in   BLOCK_W  ciphertext, valid with AES_DONE
//  BUSY            out  1        high in every state except IDLE
//  ERR             out  1        sticky error flag
//  KEY_VALID       out  1        a complete key is loaded
// BEHAVIOUR
//  Reset (async, RST_N=0): all outputs 0; state IDLE; word counter 0.
//  Word event = rising edge of SPI_DONE (registered); a held-high SPI_DONE counts once.
//  Header word [15:14]: 01 LOAD_KEY, 10 ENCRYPT, 00 STATUS, 11 CLR_ERR. Bits [13:0] are ignored.
//  IDLE: on a word event, decode the header.
//   - 01 -> RX_KEY.
//   - 10 -> RX_TEXT.
//   - 00 -> stay IDLE.
//   - 11 -> ERR<=0, stay IDLE.
//   - Always: SPI_TX_WORD<={KEY_VALID,ERR,BUSY,13'b0} with a 1-cycle SPI_TX_VALID.
//  RX_KEY/RX_TEXT: word k (k=0..WORDS-1) is written to bits [k*WORD_W +: WORD_W].
//   - First word after the header is the least-significant word.
//   - After word WORDS-1, RX_KEY sets KEY_VALID=1 and returns to IDLE.
//   - After word WORDS-1, RX_TEXT goes to RUN if KEY_VALID=1.
//   - After word WORDS-1, RX_TEXT with KEY_VALID=0: ERR=1, IDLE, AES_START not pulsed.
//   - Loading a key clears KEY_VALID at the first key word, so a partial key is never valid.
//  RUN: AES_START=1 for exactly the entry cycle.
//   - Wait for AES_DONE, then latch AES_RESULT into the transmit buffer and go to TX.
//   - Word events in RUN are ignored.
//  TX: on entry, present result word 0 with SPI_TX_VALID=1 for 1 cycle.
//   - Each word event (master dummy word) presents the next word with a 1-cycle strobe.
//   - The word event that completes word WORDS-1 -> IDLE; the status word is presented.
//   - Received data in TX is discarded.
//  Abort: rising edge of SPI_CS in RX_KEY/RX_TEXT/TX -> ERR=1, IDLE, counter 0, partial data kept.
//   - An aborted key load leaves KEY_VALID=0.
//   - In RUN, CS is ignored; the core completes and TX is entered.
//  Simultaneous CS rise and word event: the word is processed first, then the abort.
//   - If that word completes the block, there is no abort.
//  AES_DONE outside RUN is ignored. AES_KEY/AES_TEXT hold their values until rewritten.
//  Counter width is clog2(WORDS); it wraps to 0 on every return to IDLE.
// CONFIGURATION
//  CTRL_TIMEOUT_EN defined: RUN counts cycles.
//   - At TIMEOUT_CYC without AES_DONE: ERR=1, IDLE, no TX. A late AES_DONE is ignored.
//  CTRL_TIMEOUT_EN undefined: RUN waits indefinitely; no counter logic is synthesised.
// TESTING
//  1 Reset mid-RX_TEXT (RST_N low 1 cycle) -> all outputs 0, IDLE, next header decoded normally.
//  2 Key load: header 16'h4000, then words 16'h0001..16'h0008.
//    -> AES_KEY=128'h0008_0007_0006_0005_0004_0003_0002_0001, KEY_VALID=1, ERR=0.
//  3 Encrypt, core model returns 128'hA5A5...: header 16'h8000 + 8 words -> one AES_START pulse.
//    -> TX streams 8 words of 16'hA5A5, then status 16'h8000 (KEY_VALID=1, ERR=0, BUSY=0).
//  4 Encrypt with no key: 16'h8000 + 8 words -> no AES_START, ERR=1, status 16'h4000.
//    -> Header 16'hC000 clears ERR.
//  5 CS rises after 3 key words -> ERR=1, KEY_VALID=0, IDLE. A new 9-word key load succeeds.
//  6 CTRL_TIMEOUT_EN, AES_DONE never asserted -> ERR=1 at TIMEOUT_CYC cycles after AES_START.
//    -> No SPI_TX_VALID burst occurs.

Source files
------------

// File: rtl/spi_aes_frame_ctrl.sv
// Frame controller between a 16-bit SPI slave word port and a 128-bit AES core.
// Define CTRL_TIMEOUT_EN to add a watchdog on the RUN state (TIMEOUT_CYC cycles).
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for a header word
// S_RX_KEY  | assembling key words, LS word first
// S_RX_TEXT | assembling plaintext words, LS word first
// S_RUN     | core started, waiting for AES_DONE
// S_TX      | streaming ciphertext words, one per master dummy word
module spi_aes_frame_ctrl #(
   parameter int BLOCK_W     = 128,
   parameter int WORD_W      = 16,
   parameter int WORDS       = BLOCK_W / WORD_W,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               SPI_CS,
   input  logic               SPI_DONE,
   input  logic [WORD_W-1:0]  SPI_RX_WORD,
   output logic [WORD_W-1:0]  SPI_TX_WORD,
   output logic               SPI_TX_VALID,
   output logic [BLOCK_W-1:0] AES_KEY,
   output logic [BLOCK_W-1:0] AES_TEXT,
   output logic               AES_START,
   input  logic               AES_DONE,
   input  logic [BLOCK_W-1:0] AES_RESULT,
   output logic               BUSY,
   output logic               ERR,
   output logic               KEY_VALID
);

   localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

   if (WORDS * WORD_W != BLOCK_W || WORD_W < 3 || TIMEOUT_CYC < 2) begin : g_bad_cfg
      $error("spi_aes_frame_ctrl: inconsistent parameters");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_RX_KEY,
      S_RX_TEXT,
      S_RUN,
      S_TX
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               done_q, cs_q;
   logic               word_evt, cs_rise;
   logic               err_nxt, kv_nxt;
   logic [WORD_W-1:0]  tx_word_nxt;
   logic               tx_valid_nxt, start_nxt;
   logic               key_we, text_we, buf_we;
   logic               status_req, completed;
   logic [BLOCK_W-1:0] tx_buf;
   logic [1:0]         op;

   assign word_evt = SPI_DONE & ~done_q;
   assign cs_rise  = SPI_CS & ~cs_q;
   assign op       = SPI_RX_WORD[WORD_W-1 -: 2];
   assign BUSY     = (state != S_IDLE);

`ifdef CTRL_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYC);
   logic [TMR_W-1:0] tmr;

   // Loaded on RUN entry so it reaches zero TIMEOUT_CYC-1 cycles after the start pulse.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         tmr <= '0;
      else if (start_nxt)
         tmr <= TMR_W'(TIMEOUT_CYC - 1);
      else if (state == S_RUN && tmr != '0)
         tmr <= tmr - TMR_W'(1);
   end
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state        <= S_IDLE;
         cnt          <= '0;
         done_q       <= 1'b0;
         cs_q         <= 1'b0;
         ERR          <= 1'b0;
         KEY_VALID    <= 1'b0;
         SPI_TX_WORD  <= '0;
         SPI_TX_VALID <= 1'b0;
         AES_START    <= 1'b0;
         AES_KEY      <= '0;
         AES_TEXT     <= '0;
         tx_buf       <= '0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         done_q       <= SPI_DONE;
         cs_q         <= SPI_CS;
         ERR          <= err_nxt;
         KEY_VALID    <= kv_nxt;
         SPI_TX_WORD  <= tx_word_nxt;
         SPI_TX_VALID <= tx_valid_nxt;
         AES_START    <= start_nxt;
         if (key_we)
            AES_KEY[int'(cnt)*WORD_W +: WORD_W] <= SPI_RX_WORD;
         if (text_we)
            AES_TEXT[int'(cnt)*WORD_W +: WORD_W] <= SPI_RX_WORD;
         if (buf_we)
            tx_buf <= AES_RESULT;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      err_nxt      = ERR;
      kv_nxt       = KEY_VALID;
      tx_word_nxt  = SPI_TX_WORD;
      tx_valid_nxt = 1'b0;
      start_nxt    = 1'b0;
      key_we       = 1'b0;
      text_we      = 1'b0;
      buf_we       = 1'b0;
      status_req   = 1'b0;
      completed    = 1'b0;

      case (state)
         S_IDLE: begin
            if (word_evt) begin
               status_req = 1'b1;
               case (op)
                  2'b01:   state_nxt = S_RX_KEY;
                  2'b10:   state_nxt = S_RX_TEXT;
                  2'b11:   err_nxt   = 1'b0;
                  default: ;
               endcase
            end
         end

         S_RX_KEY: begin
            if (word_evt) begin
               key_we = 1'b1;
               kv_nxt = 1'b0;
               if (cnt == CNT_LAST) begin
                  kv_nxt    = 1'b1;
                  state_nxt = S_IDLE;
                  cnt_nxt   = '0;
                  completed = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            // A word arriving with the CS rise is taken first; only an incomplete load aborts.
            if (cs_rise && !completed) begin
               kv_nxt    = 1'b0;
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end
         end

         S_RX_TEXT: begin
            if (word_evt) begin
               text_we = 1'b1;
               if (cnt == CNT_LAST) begin
                  cnt_nxt   = '0;
                  completed = 1'b1;
                  if (KEY_VALID) begin
                     state_nxt = S_RUN;
                     start_nxt = 1'b1;
                  end else begin
                     err_nxt   = 1'b1;
                     state_nxt = S_IDLE;
                  end
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            if (cs_rise && !completed) begin
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end
         end

         S_RUN: begin
            if (AES_DONE) begin
               buf_we       = 1'b1;
               state_nxt    = S_TX;
               cnt_nxt      = '0;
               tx_word_nxt  = AES_RESULT[WORD_W-1:0];
               tx_valid_nxt = 1'b1;
            end
`ifdef CTRL_TIMEOUT_EN
            else if (tmr == '0) begin
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
            end
`endif
         end

         S_TX: begin
            if (word_evt) begin
               if (cnt == CNT_LAST) begin
                  state_nxt  = S_IDLE;
                  cnt_nxt    = '0;
                  status_req = 1'b1;
                  completed  = 1'b1;
               end else begin
                  cnt_nxt      = cnt + CNT_W'(1);
                  tx_word_nxt  = tx_buf[(int'(cnt) + 1)*WORD_W +: WORD_W];
                  tx_valid_nxt = 1'b1;
               end
            end
            if (cs_rise && !completed) begin
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end
         end

         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase

      // Status reflects the flags as they will stand after this word is handled.
      if (status_req) begin
         tx_word_nxt  = {kv_nxt, err_nxt, (state_nxt != S_IDLE), {(WORD_W-3){1'b0}}};
         tx_valid_nxt = 1'b1;
      end
   end

endmodule
